// File: rtl/sram_byte_stream_ctrl_pkg.sv
// Shared types and constants for the SRAM byte-stream controller.
package sram_byte_stream_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] CMD_WRITE = 8'h01;
  localparam logic [BYTE_W-1:0] CMD_READ  = 8'h02;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_LEN,
    S_WR_COLLECT,
    S_WR_STROBE,
    S_RD_STROBE,
    S_RD_CAPTURE,
    S_RD_EMIT
  } state_e;

  // States in which the controller takes bytes from the input stream.
  function automatic logic accepts_input(input state_e s);
    case (s)
      S_IDLE, S_ADDR_HI, S_ADDR_LO, S_LEN, S_WR_COLLECT: return 1'b1;
      default:                                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sram_byte_stream_ctrl_if.sv
// Byte-stream and SRAM-wrapper signal bundle for the controller.
interface sram_byte_stream_ctrl_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
);
  logic [7:0]        IN_DATA;
  logic              IN_VALID;
  logic              IN_READY;
  logic [7:0]        OUT_DATA;
  logic              OUT_VALID;
  logic              OUT_READY;
  logic              BUSY;
  logic              ERR;
  logic [ADDR_W-1:0] SRAM_ADDR;
  logic [DATA_W-1:0] SRAM_BM;
  logic [DATA_W-1:0] SRAM_DIN;
  logic              SRAM_MEN;
  logic              SRAM_WEN;
  logic              SRAM_REN;
  logic [DATA_W-1:0] SRAM_DOUT;

  // Controller side.
  modport slave (
    input  IN_DATA, IN_VALID, OUT_READY, SRAM_DOUT,
    output IN_READY, OUT_DATA, OUT_VALID, BUSY, ERR,
           SRAM_ADDR, SRAM_BM, SRAM_DIN, SRAM_MEN, SRAM_WEN, SRAM_REN
  );

  // Stream producer/consumer plus SRAM wrapper side.
  modport master (
    output IN_DATA, IN_VALID, OUT_READY, SRAM_DOUT,
    input  IN_READY, OUT_DATA, OUT_VALID, BUSY, ERR,
           SRAM_ADDR, SRAM_BM, SRAM_DIN, SRAM_MEN, SRAM_WEN, SRAM_REN
  );
endinterface

// File: rtl/sram_byte_stream_ctrl_serdes.sv
// Word-wide byte shift register: packs incoming bytes little-endian and
// unpacks a loaded word byte 0 first, with a shared byte counter.
module sram_word_serdes
  import sram_byte_stream_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              shift_in,
  input  logic              load,
  input  logic              shift_out,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic [DATA_W-1:0] word_in,
  output logic [DATA_W-1:0] pack_word_c,
  output logic [BYTE_W-1:0] next_byte_c,
  output logic              last_c
);

  localparam int unsigned BYTES = DATA_W / BYTE_W;
  localparam int unsigned CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [DATA_W-1:0] word_q;
  logic [CNT_W-1:0]  cnt_q;

  // New bytes enter at the top so the first byte ends up in bits 7:0.
  assign pack_word_c = (word_q >> BYTE_W) | (DATA_W'(byte_in) << (DATA_W - BYTE_W));
  assign next_byte_c = BYTE_W'(word_q >> BYTE_W);
  assign last_c      = (cnt_q == CNT_W'(BYTES - 1));

  // Shift register and byte counter; counter wraps after the last byte.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      word_q <= word_in;
      cnt_q  <= '0;
    end else if (shift_in || shift_out) begin
      word_q <= shift_in ? pack_word_c : (word_q >> BYTE_W);
      cnt_q  <= last_c ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/sram_byte_stream_ctrl.sv
// Byte-stream command front end for a 1024x32 SRAM wrapper: decodes
// write/read burst frames, packs/unpacks words and drives the SRAM strobes.
module sram_byte_stream_ctrl
  import sram_byte_stream_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ENA,
  sram_byte_stream_ctrl_if.slave bus
);

  state_e            state_q;
  logic              is_wr_q;
  logic [BYTE_W-1:0] addr_hi_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  words_left_q;
  logic              err_q;
  logic              out_valid_q;
  logic [BYTE_W-1:0] out_data_q;
  logic              men_q;
  logic              wen_q;
  logic              ren_q;
  logic [ADDR_W-1:0] sram_addr_q;
  logic [DATA_W-1:0] sram_din_q;

  logic              in_ready_c;
  logic              in_fire_c;
  logic              out_fire_c;
  logic              sd_clr_c;
  logic              sd_shift_in_c;
  logic              sd_load_c;
  logic              sd_shift_out_c;
  logic [DATA_W-1:0] sd_pack_word_c;
  logic [BYTE_W-1:0] sd_next_byte_c;
  logic              sd_last_c;

  // Handshake qualifiers; nothing moves while ENA is low.
  assign in_ready_c     = ENA && !RST && accepts_input(state_q);
  assign in_fire_c      = bus.IN_VALID && in_ready_c;
  assign out_fire_c     = ENA && out_valid_q && bus.OUT_READY;
  assign sd_clr_c       = in_fire_c && (state_q == S_LEN);
  assign sd_shift_in_c  = in_fire_c && (state_q == S_WR_COLLECT);
  assign sd_load_c      = ENA && (state_q == S_RD_CAPTURE);
  assign sd_shift_out_c = out_fire_c && (state_q == S_RD_EMIT);

  sram_word_serdes #(
    .DATA_W (DATA_W)
  ) u_serdes (
    .clk         (CLK),
    .rst         (RST),
    .clr         (sd_clr_c),
    .shift_in    (sd_shift_in_c),
    .load        (sd_load_c),
    .shift_out   (sd_shift_out_c),
    .byte_in     (bus.IN_DATA),
    .word_in     (bus.SRAM_DOUT),
    .pack_word_c (sd_pack_word_c),
    .next_byte_c (sd_next_byte_c),
    .last_c      (sd_last_c)
  );

  // Frame decode, burst sequencing and registered SRAM/stream outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      is_wr_q      <= 1'b0;
      addr_hi_q    <= '0;
      addr_q       <= '0;
      words_left_q <= '0;
      err_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      men_q        <= 1'b0;
      wen_q        <= 1'b0;
      ren_q        <= 1'b0;
      sram_addr_q  <= '0;
      sram_din_q   <= '0;
    end else begin
      err_q <= 1'b0;
      if (ENA) begin
        // Strobes last one enabled cycle unless re-armed below.
        men_q <= 1'b0;
        wen_q <= 1'b0;
        ren_q <= 1'b0;
        case (state_q)
          S_IDLE: begin
            if (in_fire_c) begin
              if (bus.IN_DATA == CMD_WRITE) begin
                is_wr_q <= 1'b1;
                state_q <= S_ADDR_HI;
              end else if (bus.IN_DATA == CMD_READ) begin
                is_wr_q <= 1'b0;
                state_q <= S_ADDR_HI;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          S_ADDR_HI: begin
            if (in_fire_c) begin
              addr_hi_q <= bus.IN_DATA;
              state_q   <= S_ADDR_LO;
            end
          end
          S_ADDR_LO: begin
            if (in_fire_c) begin
              addr_q  <= ADDR_W'({addr_hi_q, bus.IN_DATA});
              state_q <= S_LEN;
            end
          end
          S_LEN: begin
            if (in_fire_c) begin
              words_left_q <= LEN_W'(bus.IN_DATA);
              if (is_wr_q) begin
                state_q <= S_WR_COLLECT;
              end else begin
                state_q     <= S_RD_STROBE;
                men_q       <= 1'b1;
                ren_q       <= 1'b1;
                sram_addr_q <= addr_q;
              end
            end
          end
          S_WR_COLLECT: begin
            if (in_fire_c && sd_last_c) begin
              state_q     <= S_WR_STROBE;
              men_q       <= 1'b1;
              wen_q       <= 1'b1;
              sram_addr_q <= addr_q;
              sram_din_q  <= sd_pack_word_c;
            end
          end
          S_WR_STROBE: begin
            addr_q <= addr_q + 1'b1;
            if (words_left_q == '0) begin
              state_q <= S_IDLE;
            end else begin
              words_left_q <= words_left_q - 1'b1;
              state_q      <= S_WR_COLLECT;
            end
          end
          S_RD_STROBE: begin
            state_q <= S_RD_CAPTURE;
          end
          S_RD_CAPTURE: begin
            out_valid_q <= 1'b1;
            out_data_q  <= bus.SRAM_DOUT[BYTE_W-1:0];
            state_q     <= S_RD_EMIT;
          end
          S_RD_EMIT: begin
            if (out_fire_c) begin
              if (sd_last_c) begin
                out_valid_q <= 1'b0;
                addr_q      <= addr_q + 1'b1;
                if (words_left_q == '0) begin
                  state_q <= S_IDLE;
                end else begin
                  words_left_q <= words_left_q - 1'b1;
                  state_q      <= S_RD_STROBE;
                  men_q        <= 1'b1;
                  ren_q        <= 1'b1;
                  sram_addr_q  <= addr_q + 1'b1;
                end
              end else begin
                out_data_q <= sd_next_byte_c;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Strobes and byte mask are suppressed while ENA is low; address/data hold.
  assign bus.IN_READY  = in_ready_c;
  assign bus.OUT_DATA  = out_data_q;
  assign bus.OUT_VALID = out_valid_q;
  assign bus.BUSY      = (state_q != S_IDLE);
  assign bus.ERR       = err_q;
  assign bus.SRAM_ADDR = sram_addr_q;
  assign bus.SRAM_DIN  = sram_din_q;
  assign bus.SRAM_MEN  = men_q && ENA;
  assign bus.SRAM_WEN  = wen_q && ENA;
  assign bus.SRAM_REN  = ren_q && ENA;
  assign bus.SRAM_BM   = {DATA_W{wen_q && ENA}};

endmodule

// File: tb/tb_sram_byte_stream_ctrl.sv
// Directed bench for sram_byte_stream_ctrl with a behavioural 1024x32 SRAM.
module tb_sram_byte_stream_ctrl;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] din;
    logic [31:0] bm;
    logic        wen;
    logic        ren;
  } stb_t;

  logic clk = 1'b0;
  logic rst;
  logic ena;

  int checks  = 0;
  int errors  = 0;
  int err_cnt = 0;

  stb_t        stb_q[$];
  logic [7:0]  rx_q[$];
  logic [31:0] mem [0:1023];

  always #5 clk = ~clk;

  sram_byte_stream_ctrl_if #(.ADDR_W(10), .DATA_W(32)) bif ();

  sram_byte_stream_ctrl #(
    .ADDR_W (10),
    .DATA_W (32),
    .LEN_W  (8)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .ENA (ena),
    .bus (bif)
  );

  // SRAM wrapper model plus strobe/ERR recorder, sampled at the active edge.
  always @(posedge clk) begin
    if (bif.SRAM_MEN && bif.SRAM_WEN)
      mem[bif.SRAM_ADDR] <= (mem[bif.SRAM_ADDR] & ~bif.SRAM_BM) | (bif.SRAM_DIN & bif.SRAM_BM);
    if (bif.SRAM_MEN && bif.SRAM_REN)
      bif.SRAM_DOUT <= mem[bif.SRAM_ADDR];
    if (bif.SRAM_MEN)
      stb_q.push_back('{bif.SRAM_ADDR, bif.SRAM_DIN, bif.SRAM_BM, bif.SRAM_WEN, bif.SRAM_REN});
    if (bif.ERR)
      err_cnt++;
  end

  // Offer one byte; returns on the falling edge after it was accepted.
  task automatic send(input logic [7:0] b);
    int cyc = 0;
    bif.IN_DATA  = b;
    bif.IN_VALID = 1'b1;
    #1;
    while (!bif.IN_READY && cyc < 50) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    if (!bif.IN_READY) begin
      checks++;
      errors++;
      $display("FAIL send_timeout byte %h never accepted", b);
      bif.IN_VALID = 1'b0;
      return;
    end
    @(negedge clk);
    bif.IN_VALID = 1'b0;
  endtask

  // Collect n output bytes into rx_q; optional OUT_READY toggling with stall checks.
  task automatic recv(input int n, input bit toggle);
    int         cyc     = 0;
    bit         rdy     = 1'b1;
    bit         stalled = 1'b0;
    logic [7:0] held    = 8'h00;
    rx_q.delete();
    while (rx_q.size() < n && cyc < 300) begin
      bif.OUT_READY = toggle ? rdy : 1'b1;
      rdy = !rdy;
      if (bif.OUT_VALID) begin
        if (stalled) begin
          checks++;
          if (bif.OUT_DATA !== held) begin
            errors++;
            $display("FAIL stall_hold got %h exp %h", bif.OUT_DATA, held);
          end
        end
        if (bif.OUT_READY) begin
          rx_q.push_back(bif.OUT_DATA);
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = bif.OUT_DATA;
        end
      end
      @(negedge clk);
      cyc++;
    end
    bif.OUT_READY = 1'b0;
    checks++;
    if (rx_q.size() != n) begin
      errors++;
      $display("FAIL recv_count got %0d exp %0d", rx_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ena = 1'b1;
    bif.IN_VALID  = 1'b0;
    bif.IN_DATA   = 8'h00;
    bif.OUT_READY = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bif.IN_READY !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", bif.IN_READY); end
    checks++;
    if ({bif.BUSY, bif.OUT_VALID, bif.ERR} !== 3'b000) begin
      errors++; $display("FAIL rst_flags got %b exp 000", {bif.BUSY, bif.OUT_VALID, bif.ERR});
    end
    checks++;
    if (bif.OUT_DATA !== 8'h00) begin errors++; $display("FAIL rst_out_data got %h exp 00", bif.OUT_DATA); end
    checks++;
    if ({bif.SRAM_MEN, bif.SRAM_WEN, bif.SRAM_REN, bif.SRAM_ADDR, bif.SRAM_DIN, bif.SRAM_BM} !== '0) begin
      errors++; $display("FAIL rst_sram got addr %h din %h bm %h exp all zero", bif.SRAM_ADDR, bif.SRAM_DIN, bif.SRAM_BM);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bif.IN_READY !== 1'b1) begin errors++; $display("FAIL idle_in_ready got %b exp 1", bif.IN_READY); end
    @(negedge clk);
  endtask

  task automatic test_write_single();
    logic [7:0] v[8] = '{8'h01, 8'h00, 8'h05, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    int base = stb_q.size();
    foreach (v[i]) send(v[i]);
    checks++;
    if ({bif.SRAM_MEN, bif.SRAM_WEN, bif.SRAM_REN} !== 3'b110) begin
      errors++; $display("FAIL wr1_strobes got %b exp 110", {bif.SRAM_MEN, bif.SRAM_WEN, bif.SRAM_REN});
    end
    checks++;
    if (bif.SRAM_ADDR !== 10'd5) begin errors++; $display("FAIL wr1_addr got %0d exp 5", bif.SRAM_ADDR); end
    checks++;
    if (bif.SRAM_DIN !== 32'h44332211) begin errors++; $display("FAIL wr1_din got %h exp 44332211", bif.SRAM_DIN); end
    checks++;
    if (bif.SRAM_BM !== 32'hFFFFFFFF) begin errors++; $display("FAIL wr1_bm got %h exp ffffffff", bif.SRAM_BM); end
    checks++;
    if (bif.IN_READY !== 1'b0) begin errors++; $display("FAIL wr1_in_ready_strobe got %b exp 0", bif.IN_READY); end
    @(negedge clk);
    checks++;
    if ({bif.SRAM_MEN, bif.BUSY, bif.IN_READY, bif.SRAM_BM} !== {3'b001, 32'h0}) begin
      errors++; $display("FAIL wr1_after got men %b busy %b rdy %b bm %h exp 0 0 1 0",
                         bif.SRAM_MEN, bif.BUSY, bif.IN_READY, bif.SRAM_BM);
    end
    checks++;
    if (stb_q.size() - base != 1) begin errors++; $display("FAIL wr1_strobe_count got %0d exp 1", stb_q.size() - base); end
    checks++;
    if (mem[5] !== 32'h44332211) begin errors++; $display("FAIL wr1_mem got %h exp 44332211", mem[5]); end
  endtask

  task automatic test_write_wrap();
    logic [7:0] v[12] = '{8'h01, 8'h03, 8'hFF, 8'h01, 8'hA0, 8'hA1, 8'hA2, 8'hA3,
                          8'hA4, 8'hA5, 8'hA6, 8'hA7};
    int base = stb_q.size();
    foreach (v[i]) send(v[i]);
    checks++;
    if (bif.BUSY !== 1'b1) begin errors++; $display("FAIL wrap_busy_strobe got %b exp 1", bif.BUSY); end
    @(negedge clk);
    checks++;
    if (bif.BUSY !== 1'b0) begin errors++; $display("FAIL wrap_busy_after got %b exp 0", bif.BUSY); end
    checks++;
    if (stb_q.size() - base != 2) begin
      errors++; $display("FAIL wrap_strobe_count got %0d exp 2", stb_q.size() - base);
    end else begin
      checks++;
      if (stb_q[base].addr !== 10'd1023 || stb_q[base].din !== 32'hA3A2A1A0 || stb_q[base].wen !== 1'b1) begin
        errors++; $display("FAIL wrap_word0 got addr %0d din %h exp 1023 a3a2a1a0", stb_q[base].addr, stb_q[base].din);
      end
      checks++;
      if (stb_q[base+1].addr !== 10'd0 || stb_q[base+1].din !== 32'hA7A6A5A4 || stb_q[base+1].wen !== 1'b1) begin
        errors++; $display("FAIL wrap_word1 got addr %0d din %h exp 0 a7a6a5a4", stb_q[base+1].addr, stb_q[base+1].din);
      end
    end
  endtask

  task automatic test_read_wrap();
    logic [7:0] v[4] = '{8'h02, 8'h03, 8'hFF, 8'h01};
    int base = stb_q.size();
    int lat  = 0;
    bif.OUT_READY = 1'b0;
    foreach (v[i]) send(v[i]);
    checks++;
    if ({bif.SRAM_MEN, bif.SRAM_WEN, bif.SRAM_REN, bif.SRAM_ADDR, bif.SRAM_BM} !== {3'b101, 10'd1023, 32'h0}) begin
      errors++; $display("FAIL rd_strobe got men %b wen %b ren %b addr %0d bm %h exp 1 0 1 1023 0",
                         bif.SRAM_MEN, bif.SRAM_WEN, bif.SRAM_REN, bif.SRAM_ADDR, bif.SRAM_BM);
    end
    checks++;
    if (bif.IN_READY !== 1'b0) begin errors++; $display("FAIL rd_in_ready got %b exp 0", bif.IN_READY); end
    while (!bif.OUT_VALID && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 2) begin errors++; $display("FAIL rd_latency got %0d exp 2", lat); end
    recv(8, 1'b0);
    foreach (rx_q[i]) begin
      checks++;
      if (rx_q[i] !== 8'(8'hA0 + i)) begin errors++; $display("FAIL rd_byte%0d got %h exp %h", i, rx_q[i], 8'(8'hA0 + i)); end
    end
    checks++;
    if (stb_q.size() - base != 2) begin
      errors++; $display("FAIL rd_strobe_count got %0d exp 2", stb_q.size() - base);
    end else begin
      checks++;
      if (stb_q[base].addr !== 10'd1023 || stb_q[base+1].addr !== 10'd0 ||
          stb_q[base].ren !== 1'b1 || stb_q[base+1].ren !== 1'b1) begin
        errors++; $display("FAIL rd_strobe_addrs got %0d %0d exp 1023 0", stb_q[base].addr, stb_q[base+1].addr);
      end
    end
    checks++;
    if (bif.BUSY !== 1'b0) begin errors++; $display("FAIL rd_busy_end got %b exp 0", bif.BUSY); end
  endtask

  task automatic test_read_stall();
    logic [7:0] v[4]   = '{8'h02, 8'h00, 8'h05, 8'h00};
    logic [7:0] exp[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    foreach (v[i]) send(v[i]);
    recv(4, 1'b1);
    foreach (rx_q[i]) begin
      checks++;
      if (rx_q[i] !== exp[i]) begin errors++; $display("FAIL stall_byte%0d got %h exp %h", i, rx_q[i], exp[i]); end
    end
  endtask

  task automatic test_err();
    logic [7:0] v[8] = '{8'h01, 8'h00, 8'h07, 8'h00, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
    int base = stb_q.size();
    int e0   = err_cnt;
    send(8'h7E);
    checks++;
    if ({bif.ERR, bif.BUSY, bif.IN_READY} !== 3'b101) begin
      errors++; $display("FAIL err_pulse got err %b busy %b rdy %b exp 1 0 1", bif.ERR, bif.BUSY, bif.IN_READY);
    end
    @(negedge clk);
    checks++;
    if (bif.ERR !== 1'b0) begin errors++; $display("FAIL err_width got %b exp 0", bif.ERR); end
    checks++;
    if (err_cnt - e0 != 1 || stb_q.size() != base) begin
      errors++; $display("FAIL err_side got pulses %0d strobes %0d exp 1 0", err_cnt - e0, stb_q.size() - base);
    end
    foreach (v[i]) send(v[i]);
    checks++;
    if (bif.SRAM_MEN !== 1'b1 || bif.SRAM_ADDR !== 10'd7 || bif.SRAM_DIN !== 32'hC4C3C2C1) begin
      errors++; $display("FAIL err_next_frame got men %b addr %0d din %h exp 1 7 c4c3c2c1",
                         bif.SRAM_MEN, bif.SRAM_ADDR, bif.SRAM_DIN);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [7:0] v0[6] = '{8'h01, 8'h00, 8'h09, 8'h00, 8'h55, 8'h66};
    logic [7:0] v1[8] = '{8'h01, 8'h00, 8'h09, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    int base = stb_q.size();
    foreach (v0[i]) send(v0[i]);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bif.BUSY, bif.IN_READY} !== 2'b00) begin
      errors++; $display("FAIL rstmid_hold got busy %b rdy %b exp 0 0", bif.BUSY, bif.IN_READY);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (stb_q.size() != base) begin errors++; $display("FAIL rstmid_strobe got %0d exp 0", stb_q.size() - base); end
    foreach (v1[i]) send(v1[i]);
    checks++;
    if (bif.SRAM_MEN !== 1'b1 || bif.SRAM_ADDR !== 10'd9 || bif.SRAM_DIN !== 32'h04030201) begin
      errors++; $display("FAIL rstmid_repack got men %b addr %0d din %h exp 1 9 04030201",
                         bif.SRAM_MEN, bif.SRAM_ADDR, bif.SRAM_DIN);
    end
    @(negedge clk);
    checks++;
    if (mem[9] !== 32'h04030201) begin errors++; $display("FAIL rstmid_mem got %h exp 04030201", mem[9]); end
  endtask

  task automatic test_ena_freeze();
    logic [7:0] v[4]   = '{8'h02, 8'h00, 8'h07, 8'h00};
    logic [7:0] exp[3] = '{8'hC2, 8'hC3, 8'hC4};
    int cyc = 0;
    bif.OUT_READY = 1'b0;
    foreach (v[i]) send(v[i]);
    ena = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bif.SRAM_MEN, bif.OUT_VALID, bif.BUSY, bif.IN_READY} !== 4'b0010) begin
        errors++; $display("FAIL freeze_strobe cyc %0d got men %b ov %b busy %b rdy %b exp 0 0 1 0",
                           i, bif.SRAM_MEN, bif.OUT_VALID, bif.BUSY, bif.IN_READY);
      end
      @(negedge clk);
    end
    ena = 1'b1;
    #1;
    checks++;
    if ({bif.SRAM_MEN, bif.SRAM_REN, bif.SRAM_ADDR} !== {2'b11, 10'd7}) begin
      errors++; $display("FAIL freeze_resume got men %b ren %b addr %0d exp 1 1 7", bif.SRAM_MEN, bif.SRAM_REN, bif.SRAM_ADDR);
    end
    while (!bif.OUT_VALID && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (bif.OUT_VALID !== 1'b1 || bif.OUT_DATA !== 8'hC1) begin
      errors++; $display("FAIL freeze_first got ov %b data %h exp 1 c1", bif.OUT_VALID, bif.OUT_DATA);
    end
    bif.OUT_READY = 1'b1;
    @(negedge clk);
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bif.OUT_VALID !== 1'b1 || bif.OUT_DATA !== 8'hC2) begin
        errors++; $display("FAIL freeze_emit cyc %0d got ov %b data %h exp 1 c2", i, bif.OUT_VALID, bif.OUT_DATA);
      end
    end
    bif.OUT_READY = 1'b0;
    ena = 1'b1;
    recv(3, 1'b0);
    foreach (rx_q[i]) begin
      checks++;
      if (rx_q[i] !== exp[i]) begin errors++; $display("FAIL freeze_byte%0d got %h exp %h", i, rx_q[i], exp[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_write_single();
    test_write_wrap();
    test_read_wrap();
    test_read_stall();
    test_err();
    test_reset_mid();
    test_ena_freeze();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
